// File: rtl/ft245a_device_pkg.sv
// rtl/ft245a_device_pkg.sv - FSM state encodings and counter sizing helper for the FT245 device model
package ft245a_device_pkg;

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_WAIT   = 2'd1;
  localparam logic [1:0] R_DATA   = 2'd2;
  localparam logic [1:0] R_RECOV  = 2'd3;

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_ACTIVE = 2'd1;
  localparam logic [1:0] W_RECOV  = 2'd2;

  // Width able to hold 0..p inclusive, never narrower than two bits
  function automatic int cnt_w(input int p);
    return $clog2((p < 2) ? 2 : p) + 1;
  endfunction

endpackage

// File: rtl/ft245a_device_fifo.sv
// rtl/ft245a_device_fifo.sv - Synchronous first-word-fall-through FIFO with count/full/empty
module ft245a_device_fifo
  import ft245a_device_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  logic [W-1:0]                push_data_i,
  input  logic                        pop_i,
  output logic [W-1:0]                pop_data_o,
  output logic [cnt_w(DEPTH)-1:0]     count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A push at full is taken only alongside a pop; a pop at empty only alongside a push (bypass)
  assign do_push    = push_i & (!full_o | pop_i);
  assign do_pop     = pop_i & (!empty_o | push_i);
  assign pop_data_o = empty_o ? push_data_i : mem_q[rd_q];

  // Storage array; contents are discarded logically by the pointer reset
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  // Pointers wrap modulo depth, occupancy tracks pushes minus pops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ft245a_device.sv
// rtl/ft245a_device.sv - FT245 async FIFO device-side model; FT245A_DEVICE_SYNC_EN adds input synchronizers
module ft245a_device
  import ft245a_device_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int RX_DEPTH     = 16,
  parameter int TX_DEPTH     = 16,
  parameter int RD_DELAY     = 2,
  parameter int RXF_INACTIVE = 3,
  parameter int TXE_INACTIVE = 3
) (
  input  logic              ft_clk,
  input  logic              ft_rst,
  output logic              ft_rxfn,
  output logic              ft_txen,
  input  logic              ft_rdn,
  input  logic              ft_wrn,
  output logic [DATA_W-1:0] ft_data_out,
  output logic              ft_data_oe,
  input  logic [DATA_W-1:0] ft_data_in,
  input  logic [DATA_W-1:0] host_tx_data,
  input  logic              host_tx_valid,
  output logic              host_tx_ready,
  output logic [DATA_W-1:0] host_rx_data,
  output logic              host_rx_valid,
  input  logic              host_rx_ready,
  output logic              protocol_err
);

  localparam int RDC_W = cnt_w(RD_DELAY);
  localparam int RRC_W = cnt_w(RXF_INACTIVE);
  localparam int WRC_W = cnt_w(TXE_INACTIVE);
  localparam int RXN_W = cnt_w(RX_DEPTH);
  localparam int TXN_W = cnt_w(TX_DEPTH);

  logic              rdn_s;
  logic              wrn_s;
  logic [DATA_W-1:0] din_s;

`ifdef FT245A_DEVICE_SYNC_EN
  logic [1:0]        rdn_sync_q;
  logic [1:0]        wrn_sync_q;
  logic [DATA_W-1:0] din_sync0_q;
  logic [DATA_W-1:0] din_sync1_q;

  // Two-flop synchronizers for strobes and bus driven from another clock domain
  always_ff @(posedge ft_clk or negedge ft_rst) begin
    if (!ft_rst) begin
      rdn_sync_q  <= 2'b11;
      wrn_sync_q  <= 2'b11;
      din_sync0_q <= '0;
      din_sync1_q <= '0;
    end else begin
      rdn_sync_q  <= {rdn_sync_q[0], ft_rdn};
      wrn_sync_q  <= {wrn_sync_q[0], ft_wrn};
      din_sync0_q <= ft_data_in;
      din_sync1_q <= din_sync0_q;
    end
  end

  assign rdn_s = rdn_sync_q[1];
  assign wrn_s = wrn_sync_q[1];
  assign din_s = din_sync1_q;
`else
  assign rdn_s = ft_rdn;
  assign wrn_s = ft_wrn;
  assign din_s = ft_data_in;
`endif

  logic [DATA_W-1:0] rx_head;
  logic [RXN_W-1:0]  rx_count;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_push;
  logic              rx_pop;
  logic [TXN_W-1:0]  tx_count;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_pop;

  logic              ready_en_q;
  logic              err_q;
  logic              rd_err;
  logic              wr_err;

  logic [1:0]        rd_state_q, rd_state_d;
  logic [RDC_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [RRC_W-1:0]  rd_rec_q, rd_rec_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              oe_q, oe_d;
  logic              rxfn_q;

  logic [1:0]        wr_state_q, wr_state_d;
  logic [WRC_W-1:0]  wr_rec_q, wr_rec_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              tx_push_q, tx_push_d;
  logic              txen_q;

  assign rx_push       = host_tx_valid & host_tx_ready;
  assign tx_pop        = host_rx_valid & host_rx_ready;
  assign host_tx_ready = ready_en_q & !rx_full;
  assign host_rx_valid = !tx_empty;
  assign ft_rxfn       = rxfn_q;
  assign ft_txen       = txen_q;
  assign ft_data_out   = data_out_q;
  assign ft_data_oe    = oe_q;
  assign protocol_err  = err_q;

  ft245a_device_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i       (ft_clk),
    .rst_ni      (ft_rst),
    .push_i      (rx_push),
    .push_data_i (host_tx_data),
    .pop_i       (rx_pop),
    .pop_data_o  (rx_head),
    .count_o     (rx_count),
    .full_o      (rx_full),
    .empty_o     (rx_empty)
  );

  ft245a_device_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i       (ft_clk),
    .rst_ni      (ft_rst),
    .push_i      (tx_push_q),
    .push_data_i (wdata_q),
    .pop_i       (tx_pop),
    .pop_data_o  (host_rx_data),
    .count_o     (tx_count),
    .full_o      (tx_full),
    .empty_o     (tx_empty)
  );

  // Read FSM next state: strobe accept, data delay, pop on release, recovery hold-off
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_rec_d   = rd_rec_q;
    data_out_d = data_out_q;
    oe_d       = oe_q;
    rx_pop     = 1'b0;
    rd_err     = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (!rdn_s) begin
          if (!rxfn_q && (rx_count != '0)) begin
            rd_state_d = R_WAIT;
            rd_cnt_d   = RDC_W'(1);
            oe_d       = 1'b1;
          end else begin
            rd_err = 1'b1;
          end
        end
      end
      R_WAIT: begin
        if (rdn_s) begin
          rx_pop     = 1'b1;
          rd_err     = 1'b1;
          rd_state_d = R_RECOV;
          rd_rec_d   = RRC_W'(1);
          oe_d       = 1'b0;
          data_out_d = '0;
        end else if (rd_cnt_q >= RDC_W'(RD_DELAY)) begin
          rd_state_d = R_DATA;
          data_out_d = rx_head;
        end else begin
          rd_cnt_d = rd_cnt_q + RDC_W'(1);
        end
      end
      R_DATA: begin
        if (rdn_s) begin
          rx_pop     = 1'b1;
          rd_state_d = R_RECOV;
          rd_rec_d   = RRC_W'(1);
          oe_d       = 1'b0;
          data_out_d = '0;
        end
      end
      R_RECOV: begin
        if (rd_rec_q >= RRC_W'(RXF_INACTIVE)) rd_state_d = R_IDLE;
        else                                  rd_rec_d   = rd_rec_q + RRC_W'(1);
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read FSM registers and registered ft_rxfn
  always_ff @(posedge ft_clk or negedge ft_rst) begin
    if (!ft_rst) begin
      rd_state_q <= R_IDLE;
      rd_cnt_q   <= '0;
      rd_rec_q   <= '0;
      data_out_q <= '0;
      oe_q       <= 1'b0;
      rxfn_q     <= 1'b1;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_rec_q   <= rd_rec_d;
      data_out_q <= data_out_d;
      oe_q       <= oe_d;
      rxfn_q     <= !((rd_state_q == R_IDLE) && !rx_empty);
    end
  end

  // Write FSM next state: a write colliding with a read strobe or with ft_txen high is dropped
  always_comb begin
    wr_state_d = wr_state_q;
    wr_rec_d   = wr_rec_q;
    wdata_d    = wdata_q;
    tx_push_d  = 1'b0;
    wr_err     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (!wrn_s) begin
          if (!rdn_s || txen_q || (tx_count == TXN_W'(TX_DEPTH))) begin
            wr_err = 1'b1;
          end else begin
            wr_state_d = W_ACTIVE;
            wdata_d    = din_s;
          end
        end
      end
      W_ACTIVE: begin
        if (wrn_s) begin
          tx_push_d  = 1'b1;
          wr_state_d = W_RECOV;
          wr_rec_d   = WRC_W'(1);
        end else begin
          wdata_d = din_s;
        end
      end
      W_RECOV: begin
        if (wr_rec_q >= WRC_W'(TXE_INACTIVE)) wr_state_d = W_IDLE;
        else                                  wr_rec_d   = wr_rec_q + WRC_W'(1);
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers; the captured word enters the TX buffer one cycle after release
  always_ff @(posedge ft_clk or negedge ft_rst) begin
    if (!ft_rst) begin
      wr_state_q <= W_IDLE;
      wr_rec_q   <= '0;
      wdata_q    <= '0;
      tx_push_q  <= 1'b0;
      txen_q     <= 1'b1;
    end else begin
      wr_state_q <= wr_state_d;
      wr_rec_q   <= wr_rec_d;
      wdata_q    <= wdata_d;
      tx_push_q  <= tx_push_d;
      txen_q     <= !((wr_state_q == W_IDLE) && !tx_full);
    end
  end

  // Host-ready enable and sticky protocol violation flag
  always_ff @(posedge ft_clk or negedge ft_rst) begin
    if (!ft_rst) begin
      ready_en_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      err_q      <= err_q | rd_err | wr_err | (!rdn_s & !wrn_s);
    end
  end

endmodule

// File: tb/tb_ft245a_device.sv
// tb/tb_ft245a_device.sv - Directed self-checking bench for ft245a_device
module tb_ft245a_device;

  logic       ft_clk = 1'b0;
  logic       ft_rst;
  logic       ft_rxfn;
  logic       ft_txen;
  logic       ft_rdn;
  logic       ft_wrn;
  logic [7:0] ft_data_out;
  logic       ft_data_oe;
  logic [7:0] ft_data_in;
  logic [7:0] host_tx_data;
  logic       host_tx_valid;
  logic       host_tx_ready;
  logic [7:0] host_rx_data;
  logic       host_rx_valid;
  logic       host_rx_ready;
  logic       protocol_err;

  int n_checks = 0;
  int n_fail   = 0;

  ft245a_device dut (
    .ft_clk        (ft_clk),
    .ft_rst        (ft_rst),
    .ft_rxfn       (ft_rxfn),
    .ft_txen       (ft_txen),
    .ft_rdn        (ft_rdn),
    .ft_wrn        (ft_wrn),
    .ft_data_out   (ft_data_out),
    .ft_data_oe    (ft_data_oe),
    .ft_data_in    (ft_data_in),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .protocol_err  (protocol_err)
  );

  always #5 ft_clk = ~ft_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ft_clk);
    #1;
  endtask

  task automatic do_reset();
    ft_rst = 1'b0;
    tick();
    tick();
    ft_rst = 1'b1;
    tick();
  endtask

  task automatic host_push(input logic [7:0] d);
    host_tx_data  = d;
    host_tx_valid = 1'b1;
    tick();
    host_tx_valid = 1'b0;
  endtask

  task automatic wait_rxf_low();
    int n = 0;
    while (ft_rxfn && n < 40) begin
      tick();
      n++;
    end
    check_eq("rxf_wait", 32'(ft_rxfn), 0);
  endtask

  task automatic fpga_read(input logic [7:0] d);
    wait_rxf_low();
    ft_rdn = 1'b0;
    tick();
    check_eq("rd_oe_on", 32'(ft_data_oe), 1);
    check_eq("rd_data_early", 32'(ft_data_out), 0);
    tick();
    check_eq("rd_data_delay", 32'(ft_data_out), 0);
    tick();
    check_eq("rd_data", 32'(ft_data_out), 32'(d));
    tick();
    ft_rdn = 1'b1;
    tick();
    check_eq("rd_oe_off", 32'(ft_data_oe), 0);
  endtask

  task automatic rxf_gap();
    int n = 0;
    while (ft_rxfn && n < 20) begin
      tick();
      n++;
    end
    check_eq("rxf_gap", 32'(n), 4);
  endtask

  task automatic fpga_write(input logic [7:0] d, input bit chk);
    int n = 0;
    while (ft_txen && n < 40) begin
      tick();
      n++;
    end
    check_eq("txe_wait", 32'(ft_txen), 0);
    ft_data_in = d;
    ft_wrn     = 1'b0;
    tick();
    tick();
    ft_wrn = 1'b1;
    tick();
    if (chk) begin
      check_eq("wr_valid_lat", 32'(host_rx_valid), 0);
      tick();
      n = 1;
      check_eq("wr_valid", 32'(host_rx_valid), 1);
      check_eq("wr_data", 32'(host_rx_data), 32'(d));
      while (ft_txen && n < 20) begin
        tick();
        n++;
      end
      check_eq("txe_gap", 32'(n), 4);
    end
  endtask

  initial begin
    ft_rst        = 1'b0;
    ft_rdn        = 1'b1;
    ft_wrn        = 1'b1;
    ft_data_in    = '0;
    host_tx_data  = '0;
    host_tx_valid = 1'b0;
    host_rx_ready = 1'b0;
    tick();
    tick();

    check_eq("rst_rxfn", 32'(ft_rxfn), 1);
    check_eq("rst_txen", 32'(ft_txen), 1);
    check_eq("rst_oe", 32'(ft_data_oe), 0);
    check_eq("rst_data", 32'(ft_data_out), 0);
    check_eq("rst_tx_ready", 32'(host_tx_ready), 0);
    check_eq("rst_rx_valid", 32'(host_rx_valid), 0);
    check_eq("rst_err", 32'(protocol_err), 0);

    ft_rst = 1'b1;
    tick();
    check_eq("ready_after_rst", 32'(host_tx_ready), 1);
    check_eq("txen_after_rst", 32'(ft_txen), 0);

    // Host pushes three words, FPGA reads them back with 4-cycle strobes
    host_tx_data  = 8'h11;
    host_tx_valid = 1'b1;
    tick();
    check_eq("rxf_latency", 32'(ft_rxfn), 1);
    host_tx_data = 8'h22;
    tick();
    check_eq("rxf_low", 32'(ft_rxfn), 0);
    host_tx_data = 8'h33;
    tick();
    host_tx_valid = 1'b0;
    fpga_read(8'h11);
    rxf_gap();
    fpga_read(8'h22);
    rxf_gap();
    fpga_read(8'h33);
    repeat (6) tick();
    check_eq("rxf_empty", 32'(ft_rxfn), 1);
    check_eq("err_after_reads", 32'(protocol_err), 0);

    // FPGA writes two words, host drains them
    host_rx_ready = 1'b1;
    fpga_write(8'hA5, 1'b1);
    fpga_write(8'h5A, 1'b1);
    tick();
    check_eq("rx_drained", 32'(host_rx_valid), 0);
    check_eq("err_after_writes", 32'(protocol_err), 0);

    // Fill the RX buffer, free one slot with a read, refill it
    host_tx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host_tx_data = 8'(8'h40 + i);
      tick();
    end
    host_tx_valid = 1'b0;
    check_eq("rx_full_ready", 32'(host_tx_ready), 0);
    fpga_read(8'h40);
    check_eq("ready_after_pop", 32'(host_tx_ready), 1);
    host_push(8'h50);
    check_eq("ready_refull", 32'(host_tx_ready), 0);

    // Fill the TX buffer with the host stalled, then overrun it
    host_rx_ready = 1'b0;
    for (int i = 0; i < 16; i++) fpga_write(8'(8'h80 + i), 1'b0);
    repeat (8) tick();
    check_eq("txen_full", 32'(ft_txen), 1);
    check_eq("tx_head", 32'(host_rx_data), 32'h80);
    check_eq("err_before_overrun", 32'(protocol_err), 0);
    ft_data_in = 8'hEE;
    ft_wrn     = 1'b0;
    tick();
    check_eq("err_overrun", 32'(protocol_err), 1);
    ft_wrn = 1'b1;
    tick();
    check_eq("tx_head_kept", 32'(host_rx_data), 32'h80);

    // Simultaneous read and write strobes: read serviced, write dropped
    do_reset();
    check_eq("err_cleared", 32'(protocol_err), 0);
    host_push(8'h77);
    wait_rxf_low();
    ft_rdn     = 1'b0;
    ft_wrn     = 1'b0;
    ft_data_in = 8'h99;
    tick();
    check_eq("both_oe", 32'(ft_data_oe), 1);
    tick();
    tick();
    tick();
    check_eq("both_rd_data", 32'(ft_data_out), 32'h77);
    ft_rdn = 1'b1;
    ft_wrn = 1'b1;
    tick();
    check_eq("both_oe_off", 32'(ft_data_oe), 0);
    repeat (6) tick();
    check_eq("both_tx_unchanged", 32'(host_rx_valid), 0);
    check_eq("both_rx_empty", 32'(ft_rxfn), 1);
    check_eq("both_err", 32'(protocol_err), 1);

    // Reset asserted while the read FSM drives data
    do_reset();
    host_push(8'h3C);
    wait_rxf_low();
    ft_rdn = 1'b0;
    tick();
    tick();
    tick();
    check_eq("pre_rst_oe", 32'(ft_data_oe), 1);
    check_eq("pre_rst_data", 32'(ft_data_out), 32'h3C);
    ft_rst = 1'b0;
    #1;
    check_eq("async_rst_oe", 32'(ft_data_oe), 0);
    check_eq("async_rst_data", 32'(ft_data_out), 0);
    check_eq("async_rst_rxfn", 32'(ft_rxfn), 1);
    check_eq("async_rst_ready", 32'(host_tx_ready), 0);
    ft_rdn = 1'b1;
    tick();
    ft_rst = 1'b1;
    repeat (4) tick();
    check_eq("post_rst_rxfn", 32'(ft_rxfn), 1);
    check_eq("post_rst_rx_valid", 32'(host_rx_valid), 0);
    check_eq("post_rst_ready", 32'(host_tx_ready), 1);
    check_eq("post_rst_txen", 32'(ft_txen), 0);
    check_eq("post_rst_err", 32'(protocol_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ft245a_device.md
# ft245a_device

Synthesizable model of the FTDI side of the FT245 asynchronous FIFO protocol, clocked by `ft_clk`. It presents `ft_rxfn`/`ft_txen` to the FPGA-side bridge, answers `ft_rdn`/`ft_wrn` strobes, and buffers both directions. A host-side streaming port stands in for USB. It lets the bridge be exercised in FPGA loopback and in emulation without a behavioural interface model.

## Interface
- `DATA_W`, 8, data bus width
- `RX_DEPTH`, 16, host→FPGA words buffered (power of 2, ≥2)
- `TX_DEPTH`, 16, FPGA→host words buffered (power of 2, ≥2)
- `RD_DELAY`, 2, cycles from read strobe seen to data valid (≥1)
- `RXF_INACTIVE`, 3, cycles `ft_rxfn` is held high after each read
- `TXE_INACTIVE`, 3, cycles `ft_txen` is held high after each write

- `ft_clk`  in  1  model clock
- `ft_rst`  in  1  reset ft_rst, asynchronous, active-low
- `ft_rxfn`  out  1  low = data available to read
- `ft_txen`  out  1  low = space available to write
- `ft_rdn`  in  1  read strobe, active-low
- `ft_wrn`  in  1  write strobe, active-low
- `ft_data_out`  out  DATA_W  data to FPGA
- `ft_data_oe`  out  1  model drives bus
- `ft_data_in`  in  DATA_W  data from FPGA
- `host_tx_data`  in  DATA_W  word to send toward FPGA
- `host_tx_valid`  in  1  valid/ready push
- `host_tx_ready`  out  1  RX buffer not full
- `host_rx_data`  out  DATA_W  word written by FPGA
- `host_rx_valid`  out  1  valid/ready pop
- `host_rx_ready`  in  1  host accepts word
- `protocol_err`  out  1  sticky violation flag

## Operation
- Read FSM: `R_IDLE` → `R_WAIT` (strobe seen, counting `RD_DELAY`) → `R_DATA` (head driven) → `R_RECOV` (`RXF_INACTIVE` count) → `R_IDLE`.
- `R_IDLE` → `R_WAIT` when `ft_rdn` is sampled low. From either `R_WAIT` or `R_DATA`, `ft_rdn` sampled high pops the head word and enters `R_RECOV`.
- Write FSM: `W_IDLE` → `W_ACTIVE` when `ft_wrn` is sampled low; `ft_data_in` is registered every cycle in `W_ACTIVE`.
- When `ft_wrn` is sampled high, the last registered word is pushed and the FSM enters `W_RECOV` (`TXE_INACTIVE` count) → `W_IDLE`.
- `ft_rxfn` = !(`R_IDLE` and RX buffer non-empty); `ft_txen` = !(`W_IDLE` and TX buffer not full); both registered.
- Host ports are standard valid/ready: a transfer occurs on a cycle with valid and ready both high.
- `protocol_err` sets and holds until reset on any of:
  - `ft_rdn` low while `ft_rxfn` high in `R_IDLE` (strobe ignored)
  - `ft_wrn` low while `ft_txen` high in `W_IDLE` (strobe ignored)
  - `ft_rdn` and `ft_wrn` low in the same cycle: the read is serviced, the write is ignored
  - read strobe released in `R_WAIT`: the word is still popped
- Counters are sized $clog2(max(param,2))+1; no wrap on occupancy, pointers wrap modulo depth.

## Timing
- Reset values: `ft_rxfn`=1, `ft_txen`=1, `ft_data_oe`=0, `ft_data_out`=0, `host_tx_ready`=0, `host_rx_valid`=0, `protocol_err`=0. Both buffers are empty and both FSMs are idle.
- `host_tx_ready` rises on the first edge after reset release.
- Host push at edge N → `ft_rxfn` low after edge N+1, if the read FSM is idle.
- `ft_rdn` sampled low at edge E → `ft_data_oe`=1 after E; `ft_data_out`=head after E+RD_DELAY; it is 0 before that.
- `ft_rdn` sampled high at edge F → `ft_data_oe`=0 after F and the pop completes at F. `ft_rxfn` stays high through F+RXF_INACTIVE, then reflects occupancy.
- `ft_wrn` high sampled at edge G → word pushed at G; `host_rx_valid` high after G+1. `ft_txen` stays high through G+TXE_INACTIVE.
- Buffer full: `host_tx_ready`=0 and writes are blocked by `ft_txen`. Simultaneous push and pop at full or empty keeps the count unchanged.
- Reset asserted mid-transfer aborts immediately: buffered data is discarded and all outputs return to reset values.

## Configuration
- `FT245A_DEVICE_SYNC_EN`: defined → `ft_rdn`, `ft_wrn`, `ft_data_in` pass through 2-flop synchronizers (reset to 1/1/0). All "sampled" events then occur 2 cycles later. Undefined → inputs are used directly and must be synchronous to `ft_clk`.

## Structure
- Package `ft245a_device_pkg`: read/write state enums, and a `cnt_w()` function for counter width.
- Sub-module `ft245a_device_fifo`: synchronous FWFT FIFO with count/full/empty, instantiated for RX and TX.

## Test plan
- Host pushes 0x11,0x22,0x33; the bench reads with 4-cycle strobes → `ft_data_out` equals the pushed sequence, `ft_rxfn` high ≥3 cycles between reads, `protocol_err`=0.
- FPGA writes 0xA5,0x5A with `host_rx_ready`=1 → `host_rx_data` yields 0xA5 then 0x5A, `ft_txen` high ≥3 cycles after each write.
- Push 16 words → `host_tx_ready`=0; one read → ready=1 for one push. 16 writes with host stalled → `ft_txen` stays high, 17th write sets `protocol_err`.
- `ft_rdn` and `ft_wrn` low together → read completes, TX count unchanged, `protocol_err`=1.
- Reset asserted during `R_DATA` → `ft_data_oe`=0, `ft_rxfn`=1, buffers empty after release.
